// File: rtl/mor1kx_tlb_reload_responder_pkg.sv
// Shared definitions for the MMU TLB-reload responder: walk states, grant
// identifiers, the error-data word and the round-robin pick rule.
package mor1kx_tlb_reload_responder_pkg;

  typedef enum logic [1:0] {
    RELOAD_IDLE = 2'd0,
    RELOAD_READ = 2'd1,
    RELOAD_RESP = 2'd2,
    RELOAD_HOLD = 2'd3
  } reload_state_t;

  typedef enum logic {
    GRANT_IMMU = 1'b0,
    GRANT_DMMU = 1'b1
  } reload_grant_t;

  // Word returned on a failed read; the walkers turn it into a pagefault.
  localparam int unsigned RELOAD_MAX_WIDTH = 64;
  localparam logic [RELOAD_MAX_WIDTH-1:0] RELOAD_ERR_DATA = '0;

  function automatic reload_grant_t rr_pick(input logic immu_req,
                                            input logic dmmu_req,
                                            input reload_grant_t last);
    if (immu_req && dmmu_req)
      return (last == GRANT_DMMU) ? GRANT_IMMU : GRANT_DMMU;
    else if (dmmu_req)
      return GRANT_DMMU;
    else
      return GRANT_IMMU;
  endfunction

endpackage

// File: rtl/mor1kx_tlb_reload_responder_arb.sv
// Two-input round-robin arbiter; `lock` freezes the current owner for the
// length of a multi-read walk.
module mor1kx_rr_arb2
  import mor1kx_tlb_reload_responder_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic immu_req,
  input  logic dmmu_req,
  input  logic lock,
  output logic grant_valid,
  output logic grant_dmmu
);

  reload_grant_t last_grant;
  reload_grant_t pick;

  // While locked, last_grant is the owner of the walk in progress.
  always_comb begin
    pick        = rr_pick(immu_req, dmmu_req, last_grant);
    grant_valid = !lock && (immu_req || dmmu_req);
    grant_dmmu  = lock ? (last_grant == GRANT_DMMU) : (pick == GRANT_DMMU);
  end

  always_ff @(posedge clk) begin
    if (rst)
      last_grant <= GRANT_DMMU;
    else if (grant_valid)
      last_grant <= pick;
  end

endmodule

// File: rtl/mor1kx_tlb_reload_responder.sv
// Serves IMMU/DMMU page-table reads over a single bus read port.
// Optional bus watchdog: define MOR1KX_TLB_RELOAD_TIMEOUT_EN.
module mor1kx_tlb_reload_responder
  import mor1kx_tlb_reload_responder_pkg::*;
#(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int TIMEOUT_CYCLES       = 255
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            immu_reload_req_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] immu_reload_addr_i,
  output logic                            immu_reload_ack_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] immu_reload_data_o,
  input  logic                            dmmu_reload_req_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] dmmu_reload_addr_i,
  output logic                            dmmu_reload_ack_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] dmmu_reload_data_o,
  output logic                            bus_req_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] bus_adr_o,
  input  logic                            bus_ack_i,
  input  logic                            bus_err_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] bus_dat_i,
  output logic                            busy_o,
  output logic                            walk_err_o
);

  localparam int W = OPTION_OPERAND_WIDTH;
`ifdef MOR1KX_TLB_RELOAD_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  reload_state_t  state;
  reload_state_t  state_next;
  logic           busy;
  logic           grant_valid;
  logic           grant_dmmu;
  logic           granted_req;
  logic           timeout;
  logic           failed;
  logic           done;
  logic [W-1:0]   adr_q;
  logic [W-1:0]   data_q;
  logic [TMO_W-1:0] tmo_cnt;
  logic           walk_err_q;

  assign busy = (state != RELOAD_IDLE);

  mor1kx_rr_arb2 u_arb (
    .clk         (clk),
    .rst         (rst),
    .immu_req    (immu_reload_req_i),
    .dmmu_req    (dmmu_reload_req_i),
    .lock        (busy),
    .grant_valid (grant_valid),
    .grant_dmmu  (grant_dmmu)
  );

  // tmo_cnt counts READ cycles already spent, so the limit fires on the
  // last permitted READ cycle and bus_req_o is low right after it.
  always_comb begin
    state_next  = state;
    granted_req = grant_dmmu ? dmmu_reload_req_i : immu_reload_req_i;
    timeout     = TIMEOUT_EN && (state == RELOAD_READ) && !bus_ack_i && !bus_err_i &&
                  (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    failed      = bus_err_i || timeout;
    done        = bus_ack_i || failed;
    case (state)
      RELOAD_IDLE: if (grant_valid) state_next = RELOAD_READ;
      RELOAD_READ: if (done) state_next = granted_req ? RELOAD_RESP : RELOAD_IDLE;
      RELOAD_RESP: state_next = RELOAD_HOLD;
      RELOAD_HOLD: state_next = granted_req ? RELOAD_READ : RELOAD_IDLE;
      default:     state_next = RELOAD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RELOAD_IDLE;
      adr_q      <= '0;
      data_q     <= '0;
      tmo_cnt    <= '0;
      walk_err_q <= 1'b0;
    end else begin
      state      <= state_next;
      walk_err_q <= (state == RELOAD_READ) && failed;
      if ((state == RELOAD_IDLE && grant_valid) || (state == RELOAD_HOLD && granted_req))
        adr_q <= grant_dmmu ? dmmu_reload_addr_i : immu_reload_addr_i;
      // A flushed requester gets nothing, so the data register keeps its last word.
      if (state == RELOAD_READ && done && granted_req)
        data_q <= failed ? RELOAD_ERR_DATA[W-1:0] : bus_dat_i;
      if (state != RELOAD_READ)
        tmo_cnt <= '0;
      else
        tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign busy_o             = busy;
  assign bus_req_o          = (state == RELOAD_READ) && !rst;
  assign bus_adr_o          = adr_q;
  assign immu_reload_ack_o  = (state == RELOAD_RESP) && !grant_dmmu;
  assign dmmu_reload_ack_o  = (state == RELOAD_RESP) && grant_dmmu;
  assign immu_reload_data_o = data_q;
  assign dmmu_reload_data_o = data_q;
  assign walk_err_o         = walk_err_q;

endmodule

// File: tb/tb_mor1kx_tlb_reload_responder.sv
// Directed handshake scenarios followed by randomized IMMU/DMMU walks against
// an address-keyed memory model.
module tb_mor1kx_tlb_reload_responder;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         immu_req = 1'b0, dmmu_req = 1'b0;
  logic [W-1:0] immu_addr = '0, dmmu_addr = '0;
  logic         immu_ack, dmmu_ack;
  logic [W-1:0] immu_data, dmmu_data;
  logic         bus_req;
  logic [W-1:0] bus_adr;
  logic         bus_ack = 1'b0, bus_err = 1'b0;
  logic [W-1:0] bus_dat = '0;
  logic         busy, walk_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  mor1kx_tlb_reload_responder #(
    .OPTION_OPERAND_WIDTH (W),
    .TIMEOUT_CYCLES       (8)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .immu_reload_req_i  (immu_req),
    .immu_reload_addr_i (immu_addr),
    .immu_reload_ack_o  (immu_ack),
    .immu_reload_data_o (immu_data),
    .dmmu_reload_req_i  (dmmu_req),
    .dmmu_reload_addr_i (dmmu_addr),
    .dmmu_reload_ack_o  (dmmu_ack),
    .dmmu_reload_data_o (dmmu_data),
    .bus_req_o          (bus_req),
    .bus_adr_o          (bus_adr),
    .bus_ack_i          (bus_ack),
    .bus_err_i          (bus_err),
    .bus_dat_i          (bus_dat),
    .busy_o             (busy),
    .walk_err_o         (walk_err)
  );

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Memory model: data and error outcome are fixed functions of the address.
  function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0F0F_5A5A;
  endfunction

  function automatic logic mem_fault(input logic [W-1:0] a);
    return a[4:2] == 3'b111;
  endfunction

  function automatic logic [W-1:0] expect_word(input logic [W-1:0] a);
    return mem_fault(a) ? '0 : mem_word(a);
  endfunction

  // IMMU addresses live in the lower half, DMMU addresses in the upper half.
  function automatic logic [W-1:0] new_addr(input int r);
    logic [W-1:0] a;
    a       = $urandom();
    a[1:0]  = 2'b00;
    a[31]   = (r == 1);
    return a;
  endfunction

  // Wait for the read, stall, then complete it (kind 0 ack, 1 err, 2 both).
  task automatic serve(input string tag, input int stall, input int kind,
                       input logic [W-1:0] dat, input logic [W-1:0] adr);
    int n;
    n = 0;
    while (!bus_req && n < 40) begin
      tick();
      n++;
    end
    check_eq({tag, "_req"}, bus_req, 1'b1);
    check_eq({tag, "_adr"}, bus_adr, adr);
    repeat (stall) tick();
    bus_ack = (kind != 1);
    bus_err = (kind != 0);
    bus_dat = dat;
    tick();
    bus_ack = 1'b0;
    bus_err = 1'b0;
    bus_dat = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_bus_req"}, bus_req, 1'b0);
    check_eq({tag, "_bus_adr"}, bus_adr, '0);
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_walk_err"}, walk_err, 1'b0);
    check_eq({tag, "_immu_ack"}, immu_ack, 1'b0);
    check_eq({tag, "_dmmu_ack"}, dmmu_ack, 1'b0);
    check_eq({tag, "_immu_data"}, immu_data, '0);
    check_eq({tag, "_dmmu_data"}, dmmu_data, '0);
  endtask

  // Random-phase state.
  logic [W-1:0] cur [2];
  logic         rq [2];
  int           left [2];
  int           idle [2];
  int           acks [2];
  int           seen = 0, target = 2, exp_errs = 0, got_errs = 0;
  logic         prev_bus_req = 1'b0;
  logic         a_ack;
  logic [W-1:0] a_dat;

  task automatic bus_agent();
    bus_ack = 1'b0;
    bus_err = 1'b0;
    bus_dat = '0;
    if (bus_req) begin
      seen++;
      if (seen >= target) begin
        if (mem_fault(bus_adr)) begin
          bus_err = 1'b1;
          bus_dat = $urandom();
          exp_errs++;
        end else begin
          bus_ack = 1'b1;
          bus_dat = mem_word(bus_adr);
        end
        seen   = 0;
        target = $urandom_range(1, 4);
      end
    end else begin
      seen = 0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int t0, t1, n_hi;
  logic saw_ack;

  initial begin
    // Reset values
    rst = 1'b1;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;

    // IMMU two-level walk on a bus that answers one cycle after the request
    immu_req  = 1'b1;
    immu_addr = 32'h0000_1004;
    t0 = cyc;
    serve("t1_rd0", 1, 0, 32'h0040_2000, 32'h0000_1004);
    check_eq("t1_latency", cyc - t0, 3);
    check_eq("t1_ack0", immu_ack, 1'b1);
    check_eq("t1_data0", immu_data, 32'h0040_2000);
    check_eq("t1_no_dmmu_ack0", dmmu_ack, 1'b0);
    t1 = cyc;
    immu_addr = 32'h0040_2018;
    tick();
    check_eq("t1_hold_no_ack", immu_ack, 1'b0);
    serve("t1_rd1", 1, 0, 32'h0012_2540, 32'h0040_2018);
    check_eq("t1_ack1", immu_ack, 1'b1);
    check_eq("t1_data1", immu_data, 32'h0012_2540);
    check_eq("t1_no_dmmu_ack1", dmmu_ack, 1'b0);
    check_eq("t1_ack_gap", cyc - t1, 4);
    immu_req = 1'b0;
    tick();
    check_eq("t1_busy_hold", busy, 1'b1);
    tick();
    check_eq("t1_busy_idle", busy, 1'b0);

    // Simultaneous requests from reset: IMMU first, then alternation
    rst = 1'b1;
    tick();
    rst = 1'b0;
    immu_req  = 1'b1;
    immu_addr = 32'h0000_2000;
    dmmu_req  = 1'b1;
    dmmu_addr = 32'h8000_3000;
    serve("t2_i0", 1, 0, 32'h1111_0001, 32'h0000_2000);
    check_eq("t2_i0_ack", immu_ack, 1'b1);
    check_eq("t2_i0_dmmu_ack", dmmu_ack, 1'b0);
    check_eq("t2_i0_data", immu_data, 32'h1111_0001);
    immu_req = 1'b0;
    tick();
    tick();
    check_eq("t2_release_bus_req", bus_req, 1'b0);
    immu_req  = 1'b1;
    immu_addr = 32'h0000_2040;
    tick();
    check_eq("t2_dmmu_bus_req", bus_req, 1'b1);
    serve("t2_d0", 1, 0, 32'h2222_0002, 32'h8000_3000);
    check_eq("t2_d0_ack", dmmu_ack, 1'b1);
    check_eq("t2_d0_immu_ack", immu_ack, 1'b0);
    check_eq("t2_d0_data", dmmu_data, 32'h2222_0002);
    dmmu_req = 1'b0;
    tick();
    tick();
    serve("t2_i1", 1, 0, 32'h3333_0003, 32'h0000_2040);
    check_eq("t2_i1_ack", immu_ack, 1'b1);
    check_eq("t2_i1_data", immu_data, 32'h3333_0003);
    immu_req = 1'b0;
    tick();
    tick();

    // Bus error, then ack and err together
    immu_req  = 1'b1;
    immu_addr = 32'h0000_3008;
    serve("t3_rd0", 0, 1, 32'hDEAD_BEEF, 32'h0000_3008);
    check_eq("t3_ack0", immu_ack, 1'b1);
    check_eq("t3_data0", immu_data, '0);
    check_eq("t3_walk_err0", walk_err, 1'b1);
    immu_addr = 32'h0000_3010;
    tick();
    check_eq("t3_walk_err_pulse", walk_err, 1'b0);
    serve("t3_rd1", 2, 2, 32'hCAFE_F00D, 32'h0000_3010);
    check_eq("t3_ack1", immu_ack, 1'b1);
    check_eq("t3_data1", immu_data, '0);
    check_eq("t3_walk_err1", walk_err, 1'b1);
    immu_req = 1'b0;
    tick();
    check_eq("t3_busy_hold", busy, 1'b1);
    tick();
    check_eq("t3_busy_idle", busy, 1'b0);

    // DMMU flushes while the bus stalls
    dmmu_req  = 1'b1;
    dmmu_addr = 32'h8000_4000;
    tick();
    check_eq("t4_bus_req", bus_req, 1'b1);
    check_eq("t4_bus_adr", bus_adr, 32'h8000_4000);
    dmmu_req = 1'b0;
    n_hi = 0;
    saw_ack = 1'b0;
    repeat (5) begin
      tick();
      n_hi += int'(bus_req);
      saw_ack |= dmmu_ack;
    end
    check_eq("t4_req_held", n_hi, 5);
    bus_ack = 1'b1;
    bus_dat = 32'h7777_7777;
    tick();
    bus_ack = 1'b0;
    bus_dat = '0;
    saw_ack |= dmmu_ack;
    check_eq("t4_no_ack", saw_ack, 1'b0);
    check_eq("t4_bus_req_low", bus_req, 1'b0);
    check_eq("t4_idle", busy, 1'b0);
    check_eq("t4_data_kept", dmmu_data, '0);
    check_eq("t4_no_walk_err", walk_err, 1'b0);

`ifdef MOR1KX_TLB_RELOAD_TIMEOUT_EN
    // Bus never answers
    immu_req  = 1'b1;
    immu_addr = 32'h0000_5000;
    tick();
    n_hi = 0;
    while (bus_req && n_hi < 20) begin
      n_hi++;
      tick();
    end
    check_eq("t5_read_cycles", n_hi, 8);
    check_eq("t5_ack", immu_ack, 1'b1);
    check_eq("t5_data", immu_data, '0);
    check_eq("t5_walk_err", walk_err, 1'b1);
    immu_req = 1'b0;
    tick();
    tick();
`endif

    // Reset in READ after an IMMU grant
    immu_req  = 1'b1;
    immu_addr = 32'h0000_6000;
    tick();
    check_eq("t6_in_read", bus_req, 1'b1);
    rst = 1'b1;
    #1;
    check_eq("t6_bus_req_drop", bus_req, 1'b0);
    immu_req = 1'b0;
    tick();
    check_all_zero("t6_after_rst");
    rst       = 1'b0;
    immu_req  = 1'b1;
    immu_addr = 32'h0000_6100;
    dmmu_req  = 1'b1;
    dmmu_addr = 32'h8000_6200;
    serve("t6_prio", 1, 0, 32'h6666_0006, 32'h0000_6100);
    check_eq("t6_immu_ack", immu_ack, 1'b1);
    check_eq("t6_immu_data", immu_data, 32'h6666_0006);
    immu_req = 1'b0;
    dmmu_req = 1'b0;
    repeat (8) tick();

    // Randomized walks from both requesters
    for (int r = 0; r < 2; r++) begin
      rq[r]   = 1'b0;
      left[r] = 0;
      idle[r] = r;
      acks[r] = 0;
      cur[r]  = new_addr(r);
    end
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (walk_err) got_errs++;
      if (immu_ack || dmmu_ack)
        check_eq("rnd_one_ack", int'(immu_ack) + int'(dmmu_ack), 1);
      for (int r = 0; r < 2; r++) begin
        a_ack = (r == 0) ? immu_ack : dmmu_ack;
        a_dat = (r == 0) ? immu_data : dmmu_data;
        if (a_ack) begin
          check_eq("rnd_ack_while_req", rq[r], 1'b1);
          check_eq((r == 0) ? "rnd_immu_data" : "rnd_dmmu_data", a_dat, expect_word(cur[r]));
          acks[r]++;
        end
      end
      if (bus_req && !prev_bus_req)
        check_eq("rnd_bus_adr", (rq[0] && bus_adr == cur[0]) || (rq[1] && bus_adr == cur[1]), 1'b1);
      prev_bus_req = bus_req;
      bus_agent();
      for (int r = 0; r < 2; r++) begin
        a_ack = (r == 0) ? immu_ack : dmmu_ack;
        if (rq[r]) begin
          if (a_ack) begin
            left[r]--;
            if (left[r] == 0) begin
              rq[r]   = 1'b0;
              idle[r] = $urandom_range(0, 6);
            end else begin
              cur[r] = new_addr(r);
            end
          end else if ($urandom_range(0, 149) == 0) begin
            rq[r]   = 1'b0;
            idle[r] = 20;
          end
        end else if (idle[r] > 0) begin
          idle[r]--;
        end else begin
          rq[r]   = 1'b1;
          left[r] = $urandom_range(1, 3);
          cur[r]  = new_addr(r);
        end
      end
      immu_req  = rq[0];
      immu_addr = cur[0];
      dmmu_req  = rq[1];
      dmmu_addr = cur[1];
    end
    immu_req = 1'b0;
    dmmu_req = 1'b0;
    repeat (30) begin
      tick();
      if (walk_err) got_errs++;
      bus_agent();
    end
    check_eq("rnd_walk_err_count", got_errs, exp_errs);
    check_eq("rnd_drained", busy, 1'b0);
    check_eq("rnd_immu_active", acks[0] > 30, 1'b1);
    check_eq("rnd_dmmu_active", acks[1] > 30, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
